// File: rtl/display_scan.sv
// Time-multiplexed 8-digit seven-segment scanner with a guard-blanked slot start
// and whole-display blinking while the calculator reports an error.
module display_scan #(
    parameter int unsigned DIV         = 100000,
    parameter int unsigned GUARD       = 2,
    parameter int unsigned BLINK_SCANS = 125
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] displays [7:0],
    input  logic [1:0] status,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       scan_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    pat_q, pat_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [1:0]    status_q;
    logic          slot_end;
    logic          blank;
    logic          unused_status;

    assign unused_status = status_q[0];

    // State register; reset takes priority over any slot or blink update.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pat_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            status_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pat_q       <= pat_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            status_q    <= status;
        end
    end

    // Next-state: slot advance latches the upcoming digit's pattern; blink counts full scans.
    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        pat_d       = pat_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        slot_end    = (cnt_q == CNT_LAST);

        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            pat_d = displays[idx_d];
        end

        if (status_q[1]) begin
            if (slot_end && (idx_q == 3'd7)) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
        end else begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end
    end

    // Outputs decode registers only, so there is no input-to-output path.
    assign blank     = (cnt_q < GUARD_C) | (status_q[1] & blink_ph_q);
    assign an        = blank ? 8'hFF : ~(8'b1 << idx_q);
    assign seg       = blank ? 7'h7F : ~pat_q;
    assign scan_tick = (cnt_q == '0);

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: cycle-count based reference model compared every cycle,
// plus directed literal checks for reset, latch timing and blink boundaries.
module tb_display_scan;

    localparam int DIV   = 4;
    localparam int GUARD = 1;
    localparam int BS    = 2;

    logic       clock;
    logic       reset;
    logic [6:0] disp [7:0];
    logic [1:0] status;
    logic [7:0] an;
    logic [6:0] seg;
    logic       scan_tick;

    int tests = 0;
    int fails = 0;

    display_scan #(.DIV(DIV), .GUARD(GUARD), .BLINK_SCANS(BS)) dut (
        .clock     (clock),
        .reset     (reset),
        .displays  (disp),
        .status    (status),
        .an        (an),
        .seg       (seg),
        .scan_tick (scan_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: position is derived from cycles since reset; pattern is the
    // value of displays[digit] seen at the edge that opened the slot; blink phase
    // is the number of completed scans since error status was registered, halved by BS.
    int         m_n     = 0;
    logic [6:0] m_pat   = '0;
    logic       m_stq   = 1'b0;
    int         m_scans = 0;
    bit         started = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_n = 0; m_pat = '0; m_stq = 1'b0; m_scans = 0;
        end else begin
            if (m_n % DIV == DIV - 1) begin
                if (m_stq && ((m_n / DIV) % 8) == 7) m_scans++;
                m_pat = disp[((m_n / DIV) + 1) % 8];
            end
            if (!m_stq) m_scans = 0;
            m_stq = status[1];
            m_n++;
        end
        started = 1'b1;
    end

    always @(negedge clock) begin
        if (started) begin
            int         phase;
            int         dig;
            bit         blank;
            logic [7:0] e_an;
            logic [6:0] e_seg;
            phase = m_n % DIV;
            dig   = (m_n / DIV) % 8;
            blank = (phase < GUARD) || (m_stq && ((m_scans / BS) % 2 == 1));
            e_an  = blank ? 8'hFF : ~(8'b1 << dig);
            e_seg = blank ? 7'h7F : ~m_pat;
            chk("model_an", 32'(an), 32'(e_an));
            chk("model_seg", 32'(seg), 32'(e_seg));
            chk("model_tick", 32'(scan_tick), 32'(phase == 0));
        end
    end

    int c = 0;

    task automatic cyc();
        logic rst_at;
        rst_at = reset;
        @(posedge clock);
        #2;
        if (rst_at) c = 0;
        else c++;
    endtask

    initial begin
        int c0;
        int nt;
        int nb;
        reset  = 1'b1;
        status = 2'b00;
        for (int k = 0; k < 8; k++) disp[k] = (k == 7) ? 7'h7F : 7'(7'h01 << (k % 7));

        // Scenario 1: reset held three cycles.
        cyc();
        chk("rst_an", 32'(an), 32'h0FF);
        chk("rst_seg", 32'(seg), 32'h07F);
        chk("rst_tick", 32'(scan_tick), 32'h1);
        cyc();
        cyc();
        reset = 1'b0;
        chk("c0_an", 32'(an), 32'h0FF);
        cyc();
        chk("c1_an", 32'(an), 32'h0FE);
        chk("c1_seg", 32'(seg), 32'h07F);
        while (c != 4) cyc();
        chk("c4_an", 32'(an), 32'h0FF);
        chk("c4_tick", 32'(scan_tick), 32'h1);
        cyc();
        chk("c5_an", 32'(an), 32'h0FD);
        chk("c5_seg", 32'(seg), 32'h07D);

        // Scenario 2: forty cycles of normal scanning.
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (scan_tick) nt++;
        end
        chk("tick_count", 32'(nt), 32'd10);

        // Scenario 3: pattern change mid-slot is deferred to the next visit.
        while (c % 32 != 14) cyc();
        disp[3] = 7'h3F;
        cyc();
        chk("s3_old_seg", 32'(seg), 32'h077);
        while (c % 32 != 13) cyc();
        chk("s3_new_seg", 32'(seg), 32'h040);
        chk("s3_new_an", 32'(an), 32'h0F7);

        // Scenario 4: error status blinks every two scans, then clears.
        while (c % 32 != 0) cyc();
        status = 2'b10;
        c0 = c;
        while (c - c0 != 63) cyc();
        chk("blk_63_an", 32'(an), 32'h07F);
        cyc(); cyc();
        chk("blk_65_an", 32'(an), 32'h0FF);
        chk("blk_65_seg", 32'(seg), 32'h07F);
        while (c - c0 != 129) cyc();
        chk("blk_129_an", 32'(an), 32'h0FE);
        while (c - c0 != 201) cyc();
        chk("blk_201_an", 32'(an), 32'h0FF);
        status = 2'b00;
        cyc();
        chk("clr_202_an", 32'(an), 32'h0FB);
        repeat (6) cyc();

        // Scenario 5: status[0] alone never blanks a lit phase.
        status = 2'b01;
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if ((c % 4 != 0) && (an == 8'hFF)) nb++;
        end
        chk("s5_no_blank", 32'(nb), 32'd0);

        // Scenario 6: reset during a blank blink half restarts scanning unblinked.
        while (c % 32 != 0) cyc();
        status = 2'b10;
        c0 = c;
        while (c - c0 != 86) cyc();
        chk("s6_pre_an", 32'(an), 32'h0FF);
        reset = 1'b1;
        cyc();
        chk("s6_rst_an", 32'(an), 32'h0FF);
        chk("s6_rst_seg", 32'(seg), 32'h07F);
        chk("s6_rst_tick", 32'(scan_tick), 32'h1);
        reset = 1'b0;
        while (c != 33) cyc();
        chk("s6_33_an", 32'(an), 32'h0FE);
        while (c != 63) cyc();
        chk("s6_63_an", 32'(an), 32'h07F);
        cyc(); cyc();
        chk("s6_65_an", 32'(an), 32'h0FF);
        repeat (10) cyc();
        status = 2'b00;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
